// File: rtl/resp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : resp_tx_sched
// Purpose  : Response scheduler in front of the TX async FIFO write port.
//            Captures register-file read bytes and ALU results into one
//            holding register per source. Arbitrates round-robin when both
//            sources are pending. Serialises ALU results into FRAME_WIDTH
//            bytes and writes them to the FIFO under FIFO_FULL backpressure.
// Ports    : CLK, RST (async, active low)
//            RF_RD_DATA / RF_RD_VLD    - register-file byte and strobe
//            ALU_OUT    / ALU_OUT_VLD  - ALU result and strobe
//            FIFO_FULL                 - TX FIFO full (write domain)
//            FIFO_WR_DATA / FIFO_WR_INC - FIFO write byte and strobe
//            BUSY                      - capture pending or send in progress
//            DROP_ERR                  - one-cycle pulse, response lost
// Revision : 1.0 - initial release
// ============================================================================
module resp_tx_sched #(
  parameter int FRAME_WIDTH    = 8,
  parameter int ALU_DATA_WIDTH = 16,
  parameter int LSB_FIRST      = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [FRAME_WIDTH-1:0]    RF_RD_DATA,
  input  logic                      RF_RD_VLD,
  input  logic [ALU_DATA_WIDTH-1:0] ALU_OUT,
  input  logic                      ALU_OUT_VLD,
  input  logic                      FIFO_FULL,
  output logic [FRAME_WIDTH-1:0]    FIFO_WR_DATA,
  output logic                      FIFO_WR_INC,
  output logic                      BUSY,
  output logic                      DROP_ERR
);

  localparam int NB = ALU_DATA_WIDTH / FRAME_WIDTH;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_RF  = 2'd1,
    SEND_ALU = 2'd2
  } state_t;

  state_t                    state;
  logic                      rf_pending;
  logic                      alu_pending;
  logic [FRAME_WIDTH-1:0]    rf_hold;
  logic [ALU_DATA_WIDTH-1:0] alu_hold;
  logic [CW-1:0]             byte_cnt;
  logic                      last_grant_alu;  // 1 = ALU was granted last contention
  logic                      drop_err_q;

  logic                      wr_inc;
  logic                      rf_done;
  logic                      alu_last;
  logic                      alu_done;
  logic [CW-1:0]             byte_idx;
  logic [FRAME_WIDTH-1:0]    alu_byte;

  assign wr_inc   = (state != IDLE) && !FIFO_FULL;
  assign rf_done  = (state == SEND_RF) && wr_inc;
  assign alu_last = (byte_cnt == CW'(NB - 1));
  assign alu_done = (state == SEND_ALU) && wr_inc && alu_last;

  // Byte position within the ALU word for the current transfer slot.
  assign byte_idx = (LSB_FIRST != 0) ? byte_cnt : (CW'(NB - 1) - byte_cnt);

  always_comb begin
    alu_byte = '0;
    for (int k = 0; k < NB; k++) begin
      if (byte_idx == CW'(k)) begin
        alu_byte = alu_hold[k*FRAME_WIDTH +: FRAME_WIDTH];
      end
    end
  end

  always_comb begin
    FIFO_WR_DATA = '0;
    case (state)
      SEND_RF:  FIFO_WR_DATA = rf_hold;
      SEND_ALU: FIFO_WR_DATA = alu_byte;
      default:  FIFO_WR_DATA = '0;
    endcase
  end

  assign FIFO_WR_INC = wr_inc;
  assign BUSY        = (state != IDLE) || rf_pending || alu_pending;
  assign DROP_ERR    = drop_err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state          <= IDLE;
      rf_pending     <= 1'b0;
      alu_pending    <= 1'b0;
      rf_hold        <= '0;
      alu_hold       <= '0;
      byte_cnt       <= '0;
      last_grant_alu <= 1'b1;  // RF wins the first contention
      drop_err_q     <= 1'b0;
    end else begin
      // A strobe arriving while the source is still occupied is lost, unless
      // the occupying response leaves in this very cycle.
      drop_err_q <= (RF_RD_VLD   && rf_pending  && !rf_done) ||
                    (ALU_OUT_VLD && alu_pending && !alu_done);

      if (RF_RD_VLD && (!rf_pending || rf_done)) begin
        rf_hold    <= RF_RD_DATA;
        rf_pending <= 1'b1;
      end else if (rf_done) begin
        rf_pending <= 1'b0;
      end

      if (ALU_OUT_VLD && (!alu_pending || alu_done)) begin
        alu_hold    <= ALU_OUT;
        alu_pending <= 1'b1;
      end else if (alu_done) begin
        alu_pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          // Round-robin pointer only moves when both sources compete.
          if (rf_pending && alu_pending) begin
            if (last_grant_alu) begin
              state          <= SEND_RF;
              last_grant_alu <= 1'b0;
            end else begin
              state          <= SEND_ALU;
              last_grant_alu <= 1'b1;
            end
          end else if (rf_pending) begin
            state <= SEND_RF;
          end else if (alu_pending) begin
            state <= SEND_ALU;
          end
        end
        SEND_RF: begin
          if (rf_done) begin
            state <= IDLE;
          end
        end
        SEND_ALU: begin
          if (wr_inc) begin
            if (alu_last) begin
              byte_cnt <= '0;
              state    <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_resp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_resp_tx_sched
// Purpose  : Scoreboard bench for resp_tx_sched. Two instances (LSB-first and
//            MSB-first) share one stimulus stream; each has its own expected
//            byte queue popped by a monitor on every FIFO write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_resp_tx_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_vld;
  logic [15:0] alu_out;
  logic        alu_out_vld;
  logic        fifo_full;
  logic [7:0]  wr_data0, wr_data1;
  logic        wr_inc0, wr_inc1;
  logic        busy0, busy1;
  logic        drop0, drop1;

  int errors = 0;
  int checks = 0;
  int drops0 = 0;
  int drops1 = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  resp_tx_sched #(.FRAME_WIDTH(8), .ALU_DATA_WIDTH(16), .LSB_FIRST(1)) dut_lsb (
    .CLK(clk), .RST(rst),
    .RF_RD_DATA(rf_rd_data), .RF_RD_VLD(rf_rd_vld),
    .ALU_OUT(alu_out), .ALU_OUT_VLD(alu_out_vld),
    .FIFO_FULL(fifo_full),
    .FIFO_WR_DATA(wr_data0), .FIFO_WR_INC(wr_inc0),
    .BUSY(busy0), .DROP_ERR(drop0)
  );

  resp_tx_sched #(.FRAME_WIDTH(8), .ALU_DATA_WIDTH(16), .LSB_FIRST(0)) dut_msb (
    .CLK(clk), .RST(rst),
    .RF_RD_DATA(rf_rd_data), .RF_RD_VLD(rf_rd_vld),
    .ALU_OUT(alu_out), .ALU_OUT_VLD(alu_out_vld),
    .FIFO_FULL(fifo_full),
    .FIFO_WR_DATA(wr_data1), .FIFO_WR_INC(wr_inc1),
    .BUSY(busy1), .DROP_ERR(drop1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every FIFO write pops and compares one expected byte.
  always @(negedge clk) begin
    if (rst) begin
      if (wr_inc0) begin
        if (q0.size() == 0) check("lsb_unexpected_write", int'(wr_data0), -1);
        else check("lsb_byte", int'(wr_data0), int'(q0.pop_front()));
      end
      if (wr_inc1) begin
        if (q1.size() == 0) check("msb_unexpected_write", int'(wr_data1), -1);
        else check("msb_byte", int'(wr_data1), int'(q1.pop_front()));
      end
      if (drop0) drops0++;
      if (drop1) drops1++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy0 || busy1) && n < 50) begin
      tick();
      n++;
    end
    check({name, "_idle_timeout"}, int'(busy0 || busy1), 0);
    tick();
  endtask

  task automatic exp2(input logic [7:0] a, input logic [7:0] b);
    // a = LSB-first order first byte; MSB-first instance sees b then a
    q0.push_back(a); q0.push_back(b);
    q1.push_back(b); q1.push_back(a);
  endtask

  initial begin
    rst = 1'b0; rf_rd_data = '0; rf_rd_vld = 1'b0;
    alu_out = '0; alu_out_vld = 1'b0; fifo_full = 1'b0;
    tick(); tick();
    check("reset_wr_inc", int'(wr_inc0 | wr_inc1), 0);
    check("reset_wr_data", int'(wr_data0 | wr_data1), 0);
    check("reset_busy", int'(busy0 | busy1), 0);
    check("reset_drop", int'(drop0 | drop1), 0);
    rst = 1'b1;
    tick();

    // Single RF read: write appears exactly two cycles after the strobe.
    q0.push_back(8'h5A); q1.push_back(8'h5A);
    rf_rd_data = 8'h5A; rf_rd_vld = 1'b1;
    tick(); rf_rd_vld = 1'b0;
    check("rf_c1_no_write", int'(wr_inc0), 0);
    check("rf_c1_busy", int'(busy0), 1);
    tick();
    check("rf_c2_write", int'(wr_inc0), 1);
    check("rf_c2_data", int'(wr_data0), 8'h5A);
    tick();
    check("rf_c3_no_write", int'(wr_inc0), 0);
    check("rf_c3_busy", int'(busy0), 0);
    wait_idle("rf");

    // ALU result serialised on consecutive cycles.
    exp2(8'hEF, 8'hBE);
    alu_out = 16'hBEEF; alu_out_vld = 1'b1;
    tick(); alu_out_vld = 1'b0;
    tick();
    check("alu_b0_inc", int'(wr_inc0 & wr_inc1), 1);
    check("alu_b0_lsb", int'(wr_data0), 8'hEF);
    check("alu_b0_msb", int'(wr_data1), 8'hBE);
    tick();
    check("alu_b1_inc", int'(wr_inc0 & wr_inc1), 1);
    check("alu_b1_lsb", int'(wr_data0), 8'hBE);
    tick();
    check("alu_after_inc", int'(wr_inc0 | wr_inc1), 0);
    wait_idle("alu");

    // Backpressure: FIFO full for five cycles from c+2.
    exp2(8'h34, 8'h12);
    alu_out = 16'h1234; alu_out_vld = 1'b1; fifo_full = 1'b1;
    tick(); alu_out_vld = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_no_inc", int'(wr_inc0 | wr_inc1), 0);
      check("bp_hold_lsb", int'(wr_data0), 8'h34);
      check("bp_hold_msb", int'(wr_data1), 8'h12);
      if (i < 4) tick();
    end
    fifo_full = 1'b0;
    wait_idle("bp");

    // Contention right after reset history: RF wins first.
    q0.push_back(8'h11); q1.push_back(8'h11);
    exp2(8'hB0, 8'hA0);
    rf_rd_data = 8'h11; rf_rd_vld = 1'b1;
    alu_out = 16'hA0B0; alu_out_vld = 1'b1;
    tick(); rf_rd_vld = 1'b0; alu_out_vld = 1'b0;
    tick();
    check("cont1_rf_first", int'(wr_data0), 8'h11);
    wait_idle("cont1");

    // Second contention: ALU wins this time.
    exp2(8'hD0, 8'hC0);
    q0.push_back(8'h44); q1.push_back(8'h44);
    rf_rd_data = 8'h44; rf_rd_vld = 1'b1;
    alu_out = 16'hC0D0; alu_out_vld = 1'b1;
    tick(); rf_rd_vld = 1'b0; alu_out_vld = 1'b0;
    tick();
    check("cont2_alu_first", int'(wr_data0), 8'hD0);
    wait_idle("cont2");

    // Overflow: second RF strobe while first is still pending is dropped.
    q0.push_back(8'h22); q1.push_back(8'h22);
    fifo_full = 1'b1;
    rf_rd_data = 8'h22; rf_rd_vld = 1'b1;
    tick();
    rf_rd_data = 8'h33;
    tick(); rf_rd_vld = 1'b0;
    check("ovf_drop_pulse", int'(drop0 & drop1), 1);
    tick();
    check("ovf_drop_once", int'(drop0 | drop1), 0);
    check("ovf_data_kept", int'(wr_data0), 8'h22);
    fifo_full = 1'b0;
    wait_idle("ovf");

    // Strobe coincident with final-byte acceptance is captured, not dropped.
    q0.push_back(8'h66); q1.push_back(8'h66);
    q0.push_back(8'h77); q1.push_back(8'h77);
    rf_rd_data = 8'h66; rf_rd_vld = 1'b1;
    tick(); rf_rd_vld = 1'b0;
    tick();
    check("coin_send", int'(wr_inc0), 1);
    rf_rd_data = 8'h77; rf_rd_vld = 1'b1;
    tick(); rf_rd_vld = 1'b0;
    check("coin_no_drop", int'(drop0 | drop1), 0);
    check("coin_busy", int'(busy0), 1);
    wait_idle("coin");

    // Reset between the two ALU bytes: first byte written, second never.
    q0.push_back(8'h78); q1.push_back(8'h56);
    alu_out = 16'h5678; alu_out_vld = 1'b1;
    tick(); alu_out_vld = 1'b0;
    tick();
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("rstmid_inc", int'(wr_inc0 | wr_inc1), 0);
    check("rstmid_data", int'(wr_data0 | wr_data1), 0);
    check("rstmid_busy", int'(busy0 | busy1), 0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstmid_post_busy", int'(busy0 | busy1), 0);
    end

    check("q_lsb_empty", q0.size(), 0);
    check("q_msb_empty", q1.size(), 0);
    check("drop_count_lsb", drops0, 1);
    check("drop_count_msb", drops1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/resp_tx_sched.md
Name: resp_tx_sched

Overview:
- Response scheduler between the command datapath and the TX async FIFO write port.
- Captures register-file read bytes and ALU results, and arbitrates round-robin when both are pending.
- Serialises each ALU result into FRAME_WIDTH bytes and pushes bytes into the FIFO under FIFO_FULL backpressure.
- Removes all FIFO write sequencing from the system controller FSM.

Parameters:
- FRAME_WIDTH, 8: byte width of FIFO entries and RF data.
- ALU_DATA_WIDTH, 16: ALU result width. Must be an integer multiple of FRAME_WIDTH.
- LSB_FIRST, 1: 1 = ALU result sent least-significant byte first; 0 = most-significant byte first.

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous active-low reset
- RF_RD_DATA  input  FRAME_WIDTH  register-file read data
- RF_RD_VLD  input  1  one-cycle strobe, RF_RD_DATA valid
- ALU_OUT  input  ALU_DATA_WIDTH  ALU result
- ALU_OUT_VLD  input  1  one-cycle strobe, ALU_OUT valid
- FIFO_FULL  input  1  TX FIFO full, write-domain synchronised
- FIFO_WR_DATA  output  FRAME_WIDTH  byte to FIFO
- FIFO_WR_INC  output  1  FIFO write strobe, one byte per asserted cycle
- BUSY  output  1  any capture pending or transfer in progress
- DROP_ERR  output  1  one-cycle pulse, response lost to overflow

Behaviour:
- Reset (RST low, async):
  - state=IDLE, both pending flags 0, holding registers 0, byte counter 0.
  - last_grant=ALU, so RF wins the first contention.
  - All outputs 0. Reset mid-transfer aborts it; no further FIFO_WR_INC, and partial bytes already written stay in the FIFO.
- Capture:
  - Per source: one holding register plus a pending flag.
  - On a clock edge with *_VLD=1 and pending=0, latch the data and set pending.
  - If *_VLD=1 while pending=1 and that source's final byte is not accepted in the same cycle, drop the new data, keep the old, and pulse DROP_ERR in the next cycle.
  - *_VLD coincident with acceptance of that source's final byte: the new data is captured and pending stays 1 (no drop).
- FSM states: IDLE, SEND_RF, SEND_ALU.
  - IDLE:
    - Only RF pending -> SEND_RF.
    - Only ALU pending -> SEND_ALU.
    - Both pending -> the source not equal to last_grant. last_grant updates on entry.
    - Neither pending -> IDLE.
  - SEND_RF: single byte. Leave to IDLE on acceptance and clear RF pending.
  - SEND_ALU: NB = ALU_DATA_WIDTH/FRAME_WIDTH bytes.
    - Byte counter starts at 0 and increments per accepted byte.
    - Byte k = bits [k*FRAME_WIDTH +: FRAME_WIDTH] if LSB_FIRST, else byte NB-1-k.
    - On acceptance of byte NB-1: clear ALU pending, reset counter, go to IDLE.
- FIFO handshake (combinational outputs):
  - FIFO_WR_INC = (state==SEND_RF or SEND_ALU) and !FIFO_FULL.
  - FIFO_WR_DATA = the current byte in SEND states, else 0.
  - A byte is accepted in a cycle with FIFO_WR_INC=1. With FIFO_FULL=1, hold state, counter and data; never drop.
- Latency:
  - VLD in cycle c -> captured at end of c -> FSM in SEND from cycle c+2 -> first FIFO_WR_INC in c+2 if not full.
  - Back-to-back bytes at one per cycle.
  - After the final byte: one IDLE cycle before the next grant.
- Pending during send: a source captured while the other is sending waits; round-robin holds across bursts.
- BUSY = (state!=IDLE) | rf_pending | alu_pending.

Test Plan:
- Single RF read: RF_RD_VLD with 0x5A, FIFO not full -> exactly one FIFO_WR_INC, data 0x5A, in cycle c+2. BUSY falls the cycle after.
- ALU result, LSB_FIRST=1: ALU_OUT=0xBEEF -> writes 0xEF then 0xBE on consecutive cycles. Repeat with LSB_FIRST=0 -> 0xBE then 0xEF.
- Backpressure:
  - ALU_OUT=0x1234 with FIFO_FULL high from c+2 for 5 cycles -> no WR_INC and WR_DATA held at 0x34.
  - On release -> 0x34, 0x12 with no loss or duplication.
- Contention: RF 0x11 and ALU 0xA0B0 valid in the same cycle after reset -> RF first (0x11), then 0xB0, 0xA0. Repeat once more -> ALU first this time.
- Overflow: RF 0x22 captured while FIFO_FULL=1, then a second RF_RD_VLD 0x33 -> DROP_ERR pulses once and only 0x22 is written after release.
- Reset mid-transfer: assert RST between the two ALU bytes -> outputs 0 immediately; after release BUSY=0 and no further writes occur.
